// File: rtl/oric_ram_arbiter_if.sv
// oric_ram_arbiter_if: bus bundle between the Oric core, the OSD loader and the system RAM
// cpu_*: CPU/video RAM port and load hold; dl_*: download byte stream and load status
// rd_*: loader read-back port; ram_*: single-port RAM with registered ram_q
interface oric_ram_arbiter_if;
  logic        cpu_cs;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_hold;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_busy;
  logic        dl_overflow;
  logic [15:0] dl_count;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_q;
  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_din, dl_active, dl_wr, dl_addr, dl_data,
           rd_req, rd_addr, ram_q,
    output cpu_dout, cpu_hold, dl_busy, dl_overflow, dl_count, rd_valid, rd_data,
           ram_addr, ram_din, ram_we
  );
  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_din, dl_active, dl_wr, dl_addr, dl_data,
           rd_req, rd_addr, ram_q,
    input  cpu_dout, cpu_hold, dl_busy, dl_overflow, dl_count, rd_valid, rd_data,
           ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/oric_ram_arbiter.sv
// oric_ram_arbiter: shares the 64 KB system RAM between CPU, download FIFO and loader read-back
// clk_sys, reset_n (async active-low); bus: oric_ram_arbiter_if.slave carrying all data ports
module oric_ram_arbiter #(
  parameter int FIFO_DEPTH     = 8,
  parameter int RELEASE_CYCLES = 16
) (
  input logic               clk_sys,
  input logic               reset_n,
  oric_ram_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = RELEASE_CYCLES > 1 ? $clog2(RELEASE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RELEASE} state_t;
  state_t        state;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [CW-1:0] rel_cnt;
  logic [15:0]   last_addr;
  logic          cpu_rd_d, dl_active_d;
  logic          cpu_g, fifo_g, rd_g, full, empty, push, pop, rise, drained;
  // grants are gated by reset_n so nothing reaches the RAM while reset is held
  assign empty      = count == '0;
  assign full       = count == (AW+1)'(FIFO_DEPTH);
  assign cpu_g      = reset_n & bus.cpu_cs;
  assign fifo_g     = reset_n & ~bus.cpu_cs & ~empty;
  assign rd_g       = reset_n & ~bus.cpu_cs & empty & bus.rd_req & ~bus.rd_valid;
  assign push       = bus.dl_wr & ~full;
  assign pop        = fifo_g;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign drained    = count_next == '0;
  assign rise       = bus.dl_active & ~dl_active_d;
  assign bus.ram_addr = cpu_g ? bus.cpu_addr : fifo_g ? mem[rd_ptr][23:8] : rd_g ? bus.rd_addr : last_addr;
  assign bus.ram_din  = cpu_g ? bus.cpu_din : fifo_g ? mem[rd_ptr][7:0] : '0;
  assign bus.ram_we   = (cpu_g & bus.cpu_we) | fifo_g;
  assign bus.dl_busy  = full;
  assign bus.rd_data  = bus.rd_valid ? bus.ram_q : '0;
  always_ff @(posedge clk_sys)
    if (push) mem[wr_ptr] <= {bus.dl_addr, bus.dl_data};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      last_addr       <= '0;
      cpu_rd_d        <= 1'b0;
      dl_active_d     <= 1'b0;
      bus.cpu_dout    <= '0;
      bus.rd_valid    <= 1'b0;
      bus.dl_count    <= '0;
      bus.dl_overflow <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr + AW'(push);
      rd_ptr          <= rd_ptr + AW'(pop);
      count           <= count_next;
      last_addr       <= bus.ram_addr;
      cpu_rd_d        <= cpu_g & ~bus.cpu_we;
      dl_active_d     <= bus.dl_active;
      bus.cpu_dout    <= cpu_rd_d ? bus.ram_q : bus.cpu_dout;
      bus.rd_valid    <= rd_g;
      bus.dl_count    <= (rise ? 16'h0 : bus.dl_count) + 16'(pop);
      bus.dl_overflow <= (bus.dl_overflow & ~rise) | (bus.dl_wr & full);
    end
  // state exits look at the post-cycle FIFO fill, so the last write and the release
  // countdown start together and cpu_hold drops RELEASE_CYCLES cycles after that write
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      rel_cnt      <= '0;
      bus.cpu_hold <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.dl_active) begin
          state        <= LOAD;
          bus.cpu_hold <= 1'b1;
        end
        LOAD: if (!bus.dl_active) begin
          state   <= drained ? RELEASE : FLUSH;
          rel_cnt <= CW'(RELEASE_CYCLES - 1);
        end
        FLUSH: if (bus.dl_active) state <= LOAD;
        else if (drained) begin
          state   <= RELEASE;
          rel_cnt <= CW'(RELEASE_CYCLES - 1);
        end
        RELEASE: begin
          rel_cnt <= (bus.dl_active || rel_cnt == '0) ? '0 : rel_cnt - CW'(1);
          if (bus.dl_active) state <= LOAD;
          else if (rel_cnt <= CW'(1)) begin
            state        <= IDLE;
            bus.cpu_hold <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/oric_ram_arbiter.md
Name: oric_ram_arbiter

Overview:
- Shares the single-port 64 KB system RAM between three requesters: the Oric CPU/video bus, the OSD download stream (ioctl byte writes for program/tape image injection), and a low-priority read-back port used by the loader logic.
- Buffers download bytes in a small FIFO, fits them into cycles the CPU leaves free, and sequences a CPU hold across the whole load.
- Sits between the oricatmos core RAM port and the RAM array in the emu top level.

Parameters:
- FIFO_DEPTH, 8, download FIFO entries; power of 2, minimum 2.
- RELEASE_CYCLES, 16, clk_sys cycles that cpu_hold stays asserted after the last buffered byte is written.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_cs  in  1  CPU/video bus RAM access this cycle
- cpu_we  in  1  CPU write strobe; qualified by cpu_cs
- cpu_addr  in  16  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- cpu_hold  out  1  CPU halt request during a load
- dl_active  in  1  download in progress (ioctl_download, index-qualified)
- dl_wr  in  1  one download byte this cycle
- dl_addr  in  16  target RAM address of the byte
- dl_data  in  8  download byte
- dl_busy  out  1  FIFO full
- dl_overflow  out  1  sticky flag: a byte was dropped
- dl_count  out  16  bytes committed to RAM in the current load
- rd_req  in  1  read-back request; held until rd_valid
- rd_addr  in  16  read-back address
- rd_valid  out  1  one-cycle read-back data strobe
- rd_data  out  8  read-back data
- ram_addr  out  16  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM read data; registered, 1-cycle latency

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; release counter 0.
- Assertion of reset_n low mid-load discards the FIFO contents and produces no further ram_we.
- Per-cycle grant, combinational, fixed priority:
  1. cpu_cs: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we.
  2. Otherwise, FIFO non-empty: pop the head; ram_addr/ram_din come from the head entry; ram_we=1; dl_count increments by 1.
  3. Otherwise, rd_req: ram_addr=rd_addr, ram_we=0.
  4. Otherwise: ram_addr holds its last value, ram_we=0.
- CPU reads: cpu_dout registers ram_q in the cycle after a granted CPU read and holds that value until the next CPU read. Total latency from cpu_cs is 2 cycles; the core already expects a registered RAM.
- Read-back: the cycle after a read-back grant, rd_valid=1 and rd_data=ram_q. rd_req is not re-granted in the cycle rd_valid is high.
- FIFO push: push when dl_wr=1 and the FIFO is not full.
  - dl_wr while full drops the byte and sets dl_overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - dl_busy = (count == FIFO_DEPTH).
- dl_count wraps 0xFFFF to 0x0000.
- Rising edge of dl_active clears dl_overflow and dl_count.
- State machine (cpu_hold=1 in every state except IDLE):
  - IDLE -> LOAD on dl_active=1.
  - LOAD -> FLUSH on dl_active=0 with FIFO non-empty.
  - LOAD -> RELEASE on dl_active=0 with FIFO empty; loads the counter with RELEASE_CYCLES-1.
  - FLUSH -> RELEASE when the FIFO becomes empty.
  - FLUSH -> LOAD if dl_active re-asserts; the FIFO is kept.
  - RELEASE: counter decrements; at 0 go to IDLE. dl_active=1 during RELEASE returns to LOAD.
- dl_wr in IDLE is accepted into the FIFO and starts nothing; the core treats this as a protocol error and does not rely on it.

Test Plan:
- Reset with random inputs -> all outputs 0. Release reset, cpu_cs=1, cpu_we=1, addr 0x1234, din 0xA5 -> ram_we=1, ram_addr=0x1234. A read of 0x1234 two cycles later -> cpu_dout=0xA5.
- dl_active=1, 4 bytes 0x11..0x14 to 0x0500..0x0503 with cpu_cs=0 -> cpu_hold=1 the next cycle; 4 ram_we cycles; dl_count=4. Drop dl_active -> cpu_hold falls exactly RELEASE_CYCLES cycles after the last write.
- cpu_cs=1 continuously while 8 bytes are written back-to-back -> dl_busy=1 after the 8th byte. A 9th byte sets dl_overflow=1. Drop cpu_cs -> exactly 8 writes drain in order.
- rd_req on 0x0500 while the FIFO drains -> rd_valid only after the FIFO is empty; rd_data=0x11.
- Simultaneous push and pop with count=3 -> count stays 3 and data order is preserved through a pointer wrap (14 bytes total).
- Assert reset_n low with 5 bytes buffered -> no ram_we after reset; state IDLE; cpu_hold=0; dl_count=0.
